// File: rtl/arm_mem_pkg.sv
// Shared definitions for the store buffer and its load-forwarding selector.
//   SB_DEPTH    : default number of buffered stores
//   WADDR_W     : word-address width (byte address bits [31:2])
//   sb_entry_t  : one buffered store {word address, data}
package arm_mem_pkg;

  localparam int SB_DEPTH = 4;
  localparam int WADDR_W  = 30;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [31:0]        data;
  } sb_entry_t;

endpackage

// File: rtl/arm_sb_fwd.sv
// Load-forwarding selector: picks the youngest valid buffered store whose word
// address matches the load address, otherwise passes backing-memory data.
//   ent_addr  : flattened word addresses of all slots
//   ent_data  : flattened data of all slots
//   valid     : per-slot occupancy mask
//   tail      : next write slot; the youngest entry sits at tail-1
//   addr      : load word address
//   mem_rdata : backing-memory read data (fallback)
//   rdata     : forwarded load data
module arm_sb_fwd
  import arm_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH*WADDR_W-1:0] ent_addr,
  input  logic [DEPTH*32-1:0]      ent_data,
  input  logic [DEPTH-1:0]         valid,
  input  logic [PTR_W-1:0]         tail,
  input  logic [WADDR_W-1:0]       addr,
  input  logic [31:0]              mem_rdata,
  output logic [31:0]              rdata
);

  logic [DEPTH-1:0] match;
  logic [31:0]      data_arr [DEPTH];
  logic [PTR_W-1:0] slot;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign match[gi]    = valid[gi] && (ent_addr[gi*WADDR_W +: WADDR_W] == addr);
      assign data_arr[gi] = ent_data[gi*32 +: 32];
    end
  endgenerate

  // Walk from the oldest slot to the youngest; a later hit overrides an
  // earlier one, so the youngest matching store wins.
  always_comb begin
    rdata = mem_rdata;
    slot  = '0;
    for (int age = DEPTH - 1; age >= 0; age--) begin
      slot = tail - PTR_W'(age + 1);
      if (match[slot]) rdata = data_arr[slot];
    end
  end

endmodule

// File: rtl/arm_store_buffer.sv
// Processor store buffer: a circular FIFO of pending word stores drained to the
// backing memory in order, with combinational load forwarding.
//   clk, reset                  : clock, asynchronous active-high reset
//   MemWrite/DataAdr/WriteData  : processor store request (also load address)
//   ReadData                    : load data (forwarded or from memory)
//   Stall                       : store not accepted, buffer full
//   Empty                       : no buffered stores
//   MemAdr/MemRdata             : backing-memory read port
//   WrValid/WrAdr/WrData/WrReady: head-store write handshake to memory
module arm_store_buffer
  import arm_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Empty,
  output logic [31:0] MemAdr,
  input  logic [31:0] MemRdata,
  output logic        WrValid,
  output logic [31:0] WrAdr,
  output logic [31:0] WrData,
  input  logic        WrReady
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  sb_entry_t        entry_reg [DEPTH];

  logic full, push, pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign Stall   = MemWrite && full;
  assign push    = MemWrite && !full;
  assign WrValid = (count_reg != '0);
  assign Empty   = (count_reg == '0);
  assign pop     = WrValid && WrReady;
  assign MemAdr  = DataAdr;
  assign WrAdr   = {entry_reg[head_reg].addr, 2'b00};
  assign WrData  = entry_reg[head_reg].data;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (push) tail_next = tail_reg + PTR_W'(1);
    if (pop)  head_next = head_reg + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entry payload carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) entry_reg[tail_reg] <= '{addr: DataAdr[31:2], data: WriteData};
  end

  // A slot is live when its distance from head is below the occupancy count.
  logic [DEPTH-1:0]         slot_valid;
  logic [DEPTH*WADDR_W-1:0] ent_addr;
  logic [DEPTH*32-1:0]      ent_data;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] off;
      assign off                            = PTR_W'(gi) - head_reg;
      assign slot_valid[gi]                 = ({1'b0, off} < count_reg);
      assign ent_addr[gi*WADDR_W +: WADDR_W] = entry_reg[gi].addr;
      assign ent_data[gi*32 +: 32]           = entry_reg[gi].data;
    end
  endgenerate

  arm_sb_fwd #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd (
    .ent_addr  (ent_addr),
    .ent_data  (ent_data),
    .valid     (slot_valid),
    .tail      (tail_reg),
    .addr      (DataAdr[31:2]),
    .mem_rdata (MemRdata),
    .rdata     (ReadData)
  );

endmodule

// File: tb/tb_arm_store_buffer.sv
module tb_arm_store_buffer;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Empty;
  logic [31:0] MemAdr;
  logic [31:0] MemRdata;
  logic        WrValid;
  logic [31:0] WrAdr;
  logic [31:0] WrData;
  logic        WrReady;

  arm_store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Empty     (Empty),
    .MemAdr    (MemAdr),
    .MemRdata  (MemRdata),
    .WrValid   (WrValid),
    .WrAdr     (WrAdr),
    .WrData    (WrData),
    .WrReady   (WrReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        wrr;
    logic        stall;
    logic        wrv;
    logic [31:0] wadr;
    logic [31:0] wdat;
    logic        empty;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                              input logic wrr, input logic stall, input logic wrv,
                              input logic [31:0] wadr, input logic [31:0] wdat,
                              input logic empty, input logic [31:0] rd);
    vec_t v;
    v.mw = mw; v.adr = adr; v.wd = wd; v.wrr = wrr; v.stall = stall;
    v.wrv = wrv; v.wadr = wadr; v.wdat = wdat; v.empty = empty; v.rd = rd;
    return v;
  endfunction

  localparam logic [31:0] DEAD = 32'h0000_DEAD;

  vec_t tbl[$];

  initial begin
    int n_sent, n_pop, guard;

    // Inputs sampled by the DUT at each posedge; rows give inputs and the
    // outputs expected during that same cycle (before the edge).
    tbl.push_back(mk(0, 32'h000, 32'h0,         1, 0, 0, 32'h0,   32'h0,         1, DEAD));
    tbl.push_back(mk(1, 32'h102, 32'hAAAA0001,  1, 0, 0, 32'h0,   32'h0,         1, DEAD));
    tbl.push_back(mk(0, 32'h100, 32'h0,         1, 0, 1, 32'h100, 32'hAAAA0001,  0, 32'hAAAA0001));
    tbl.push_back(mk(0, 32'h100, 32'h0,         1, 0, 0, 32'h0,   32'h0,         1, DEAD));
    tbl.push_back(mk(1, 32'h010, 32'h11,        0, 0, 0, 32'h0,   32'h0,         1, DEAD));
    tbl.push_back(mk(1, 32'h014, 32'h22,        0, 0, 1, 32'h010, 32'h11,        0, DEAD));
    tbl.push_back(mk(1, 32'h018, 32'h33,        0, 0, 1, 32'h010, 32'h11,        0, DEAD));
    tbl.push_back(mk(1, 32'h01C, 32'h44,        0, 0, 1, 32'h010, 32'h11,        0, DEAD));
    tbl.push_back(mk(1, 32'h020, 32'h55,        0, 1, 1, 32'h010, 32'h11,        0, DEAD));
    tbl.push_back(mk(1, 32'h020, 32'h55,        1, 1, 1, 32'h010, 32'h11,        0, DEAD));
    tbl.push_back(mk(1, 32'h020, 32'h55,        1, 0, 1, 32'h014, 32'h22,        0, DEAD));
    tbl.push_back(mk(0, 32'h010, 32'h0,         1, 0, 1, 32'h018, 32'h33,        0, DEAD));
    tbl.push_back(mk(0, 32'h020, 32'h0,         1, 0, 1, 32'h01C, 32'h44,        0, 32'h55));
    tbl.push_back(mk(0, 32'h020, 32'h0,         1, 0, 1, 32'h020, 32'h55,        0, 32'h55));
    tbl.push_back(mk(0, 32'h020, 32'h0,         1, 0, 0, 32'h0,   32'h0,         1, DEAD));
    tbl.push_back(mk(1, 32'h040, 32'h1,         0, 0, 0, 32'h0,   32'h0,         1, DEAD));
    tbl.push_back(mk(1, 32'h040, 32'h2,         0, 0, 1, 32'h040, 32'h1,         0, 32'h1));
    tbl.push_back(mk(0, 32'h042, 32'h0,         0, 0, 1, 32'h040, 32'h1,         0, 32'h2));
    tbl.push_back(mk(0, 32'h044, 32'h0,         0, 0, 1, 32'h040, 32'h1,         0, DEAD));
    tbl.push_back(mk(0, 32'h040, 32'h0,         1, 0, 1, 32'h040, 32'h1,         0, 32'h2));
    tbl.push_back(mk(0, 32'h040, 32'h0,         1, 0, 1, 32'h040, 32'h2,         0, 32'h2));
    tbl.push_back(mk(0, 32'h040, 32'h0,         1, 0, 0, 32'h0,   32'h0,         1, DEAD));
    tbl.push_back(mk(1, 32'h080, 32'hA,         0, 0, 0, 32'h0,   32'h0,         1, DEAD));
    tbl.push_back(mk(1, 32'h084, 32'hB,         1, 0, 1, 32'h080, 32'hA,         0, DEAD));
    tbl.push_back(mk(0, 32'h080, 32'h0,         0, 0, 1, 32'h084, 32'hB,         0, DEAD));
    tbl.push_back(mk(0, 32'h084, 32'h0,         1, 0, 1, 32'h084, 32'hB,         0, 32'hB));
    tbl.push_back(mk(0, 32'h084, 32'h0,         1, 0, 0, 32'h0,   32'h0,         1, DEAD));

    reset = 1'b1; MemWrite = 1'b1; DataAdr = '0; WriteData = '0;
    MemRdata = DEAD; WrReady = 1'b0;
    #12;
    chk("reset_wrvalid", 32'(WrValid), 32'd0);
    chk("reset_empty",   32'(Empty),   32'd1);
    chk("reset_stall",   32'(Stall),   32'd0);
    @(negedge clk); reset = 1'b0; MemWrite = 1'b0;

    // Table-driven vectors
    foreach (tbl[i]) begin
      @(negedge clk);
      MemWrite = tbl[i].mw; DataAdr = tbl[i].adr; WriteData = tbl[i].wd; WrReady = tbl[i].wrr;
      #1;
      chk($sformatf("v%0d_stall", i),   32'(Stall),   32'(tbl[i].stall));
      chk($sformatf("v%0d_wrvalid", i), 32'(WrValid), 32'(tbl[i].wrv));
      chk($sformatf("v%0d_empty", i),   32'(Empty),   32'(tbl[i].empty));
      chk($sformatf("v%0d_readdata", i), ReadData,    tbl[i].rd);
      chk($sformatf("v%0d_memadr", i),  MemAdr,       tbl[i].adr);
      if (tbl[i].wrv) begin
        chk($sformatf("v%0d_wradr", i),  WrAdr,  tbl[i].wadr);
        chk($sformatf("v%0d_wrdata", i), WrData, tbl[i].wdat);
      end
      $display("vec %0d mw=%0b adr=%h wrr=%0b -> stall=%0b wrv=%0b wradr=%h rd=%h",
               i, tbl[i].mw, tbl[i].adr, tbl[i].wrr, Stall, WrValid, WrAdr, ReadData);
    end

    // Wrap: fill, then hold push and pop for 9 cycles, then drain.
    n_sent = 0; n_pop = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      MemWrite = 1'b1; WrReady = 1'b0;
      DataAdr = 32'h200 + 32'(4 * n_sent); WriteData = 32'h3000 + 32'(n_sent);
      #1;
      chk("wrap_fill_stall", 32'(Stall), 32'd0);
      n_sent++;
    end
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      MemWrite = 1'b1; WrReady = 1'b1;
      DataAdr = 32'h200 + 32'(4 * n_sent); WriteData = 32'h3000 + 32'(n_sent);
      #1;
      if (c == 0) chk("wrap_full_stall", 32'(Stall), 32'd1);
      chk("wrap_wrvalid", 32'(WrValid), 32'd1);
      chk("wrap_wradr", WrAdr,  32'h200 + 32'(4 * n_pop));
      chk("wrap_wrdata", WrData, 32'h3000 + 32'(n_pop));
      n_pop++;
      if (!Stall) n_sent++;
      $display("wrap cycle %0d pop=%h stall=%0b", c, WrAdr, Stall);
    end
    guard = 0;
    @(negedge clk); MemWrite = 1'b0; WrReady = 1'b1; #1;
    while (WrValid && guard < 20) begin
      chk("drain_wradr", WrAdr,  32'h200 + 32'(4 * n_pop));
      chk("drain_wrdata", WrData, 32'h3000 + 32'(n_pop));
      n_pop++; guard++;
      @(negedge clk); #1;
    end
    chk("drain_empty", 32'(Empty), 32'd1);
    chk("wrap_sent", 32'(n_sent), 32'd12);
    chk("wrap_popped", 32'(n_pop), 32'd12);
    $display("wrap done sent=%0d popped=%0d", n_sent, n_pop);

    // Asynchronous reset with stores pending
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      MemWrite = 1'b1; WrReady = 1'b0;
      DataAdr = 32'h300 + 32'(4 * c); WriteData = 32'h4000 + 32'(c);
    end
    @(negedge clk); MemWrite = 1'b0; #1;
    chk("pre_rst_wrvalid", 32'(WrValid), 32'd1);
    @(posedge clk); #3;
    reset = 1'b1; #1;
    chk("async_rst_wrvalid", 32'(WrValid), 32'd0);
    chk("async_rst_empty",   32'(Empty),   32'd1);
    MemWrite = 1'b1; #1;
    chk("async_rst_stall",   32'(Stall),   32'd0);
    MemWrite = 1'b0;
    @(posedge clk); #2; reset = 1'b0;
    $display("reset asserted between edges and released");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); MemWrite = 1'b0; WrReady = 1'b1; #1;
      chk("post_rst_wrvalid", 32'(WrValid), 32'd0);
    end
    @(negedge clk); MemWrite = 1'b1; WrReady = 1'b0; DataAdr = 32'h400; WriteData = 32'h5A5A; #1;
    chk("post_rst_push_stall", 32'(Stall), 32'd0);
    @(negedge clk); MemWrite = 1'b0; #1;
    chk("post_rst_new_wrvalid", 32'(WrValid), 32'd1);
    chk("post_rst_new_wradr", WrAdr, 32'h400);
    chk("post_rst_new_wrdata", WrData, 32'h5A5A);
    $display("post-reset store presented adr=%h data=%h", WrAdr, WrData);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
